spawn_controller: RTL

- Downstream consumer of random_generator. It paces obstacle spawns with a programmable timer.
- For each spawn it drives dir and pulses capture into random_generator, waits for the generator pipeline to settle, then latches random_coord.
- It emits one spawn record per spawn to the object/draw logic over a valid/ready handshake.
- random_coord format: x = [14:7] (0..159), y = [6:0] (0..119). The value 15'b0 is the generator's invalid/default code.

---
 rtl/spawn_controller.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/spawn_controller.sv
`default_nettype none
// ============================================================================
// Module      : spawn_controller
// Description : Paces obstacle spawns with a programmable idle timer. Each
//               spawn strobes capture into random_generator, waits for its
//               pipeline to settle, latches random_coord and hands one spawn
//               record downstream over a valid/ready handshake. Zero coords
//               are dropped and counted.
// Revision    : 1.0 - initial release
// ============================================================================
module spawn_controller #(
  parameter int PERIOD_W      = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int COUNT_W       = 8
) (
  input  logic                spawn_clock,
  input  logic                spawn_reset,
  input  logic                spawn_enable,
  input  logic [PERIOD_W-1:0] spawn_period,
  output logic [1:0]          dir,
  output logic                capture,
  input  logic [14:0]         random_coord,
  output logic                obj_valid,
  input  logic                obj_ready,
  output logic [7:0]          obj_x,
  output logic [6:0]          obj_y,
  output logic [1:0]          obj_dir,
  output logic [COUNT_W-1:0]  spawn_count,
  output logic [COUNT_W-1:0]  drop_count,
  output logic                busy
);

  // Settle counter runs 0..SETTLE_CYCLES-1; keep it at least one bit wide.
  localparam int c_settle_w = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [c_settle_w-1:0] c_settle_last = c_settle_w'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_SETTLE  = 3'd2,
    S_LATCH   = 3'd3,
    S_EMIT    = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PERIOD_W-1:0]   r_timer;
  logic [PERIOD_W-1:0]   w_timer_nxt;
  logic [c_settle_w-1:0] r_settle;
  logic [c_settle_w-1:0] w_settle_nxt;
  logic [PERIOD_W-1:0]   w_period_last;

  logic                  w_capture_nxt;
  logic                  w_valid_nxt;
  logic [1:0]            w_dir_nxt;
  logic [7:0]            w_x_nxt;
  logic [6:0]            w_y_nxt;
  logic [1:0]            w_obj_dir_nxt;
  logic [COUNT_W-1:0]    w_spawn_count_nxt;
  logic [COUNT_W-1:0]    w_drop_count_nxt;

  // A period of zero behaves as one idle cycle per spawn.
  assign w_period_last = (spawn_period == '0) ? '0 : (spawn_period - PERIOD_W'(1));

  // busy is the only combinational output: anything but IDLE.
  assign busy = (r_state != S_IDLE);

  // State register plus all registered outputs; reset aborts any spawn.
  always_ff @(posedge spawn_clock or posedge spawn_reset) begin
    if (spawn_reset) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_settle    <= '0;
      capture     <= 1'b0;
      obj_valid   <= 1'b0;
      dir         <= 2'd0;
      obj_x       <= 8'd0;
      obj_y       <= 7'd0;
      obj_dir     <= 2'd0;
      spawn_count <= '0;
      drop_count  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_settle    <= w_settle_nxt;
      capture     <= w_capture_nxt;
      obj_valid   <= w_valid_nxt;
      dir         <= w_dir_nxt;
      obj_x       <= w_x_nxt;
      obj_y       <= w_y_nxt;
      obj_dir     <= w_obj_dir_nxt;
      spawn_count <= w_spawn_count_nxt;
      drop_count  <= w_drop_count_nxt;
    end
  end

  // Next-state and next-output decode; everything holds unless a state acts.
  always_comb begin
    w_state_nxt       = r_state;
    w_timer_nxt       = r_timer;
    w_settle_nxt      = r_settle;
    w_capture_nxt     = 1'b0;
    w_valid_nxt       = obj_valid;
    w_dir_nxt         = dir;
    w_x_nxt           = obj_x;
    w_y_nxt           = obj_y;
    w_obj_dir_nxt     = obj_dir;
    w_spawn_count_nxt = spawn_count;
    w_drop_count_nxt  = drop_count;

    case (r_state)
      S_IDLE: begin
        if (spawn_enable) begin
          // Equality compare: a period lowered below the timer fires on wrap.
          if (r_timer == w_period_last) begin
            w_state_nxt   = S_CAPTURE;
            w_timer_nxt   = '0;
            w_capture_nxt = 1'b1;
          end else begin
            w_timer_nxt = r_timer + PERIOD_W'(1);
          end
        end else begin
          w_timer_nxt = '0;
        end
      end

      S_CAPTURE: begin
        w_state_nxt  = S_SETTLE;
        w_settle_nxt = '0;
      end

      S_SETTLE: begin
        if (r_settle == c_settle_last) begin
          w_state_nxt = S_LATCH;
        end else begin
          w_settle_nxt = r_settle + c_settle_w'(1);
        end
      end

      S_LATCH: begin
        w_x_nxt       = random_coord[14:7];
        w_y_nxt       = random_coord[6:0];
        w_obj_dir_nxt = dir;
        if (random_coord == 15'd0) begin
          // Generator produced its invalid code: skip this spawn.
          w_state_nxt = S_IDLE;
          w_dir_nxt   = dir + 2'd1;
          if (drop_count != '1) begin
            w_drop_count_nxt = drop_count + COUNT_W'(1);
          end
        end else begin
          w_state_nxt = S_EMIT;
          w_valid_nxt = 1'b1;
        end
      end

      S_EMIT: begin
        if (obj_valid && obj_ready) begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b0;
          w_dir_nxt   = dir + 2'd1;
          if (spawn_count != '1) begin
            w_spawn_count_nxt = spawn_count + COUNT_W'(1);
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
